wb_arb: RTL and testbench
=========================

Name: wb_arb

Overview:
- Arbitrates the single register-file write port between the in-order pipeline write-back (the output of the WB stage) and a long-latency unit (LLU: multi-cycle mul/div, late loads).
- Pipeline writes always win. LLU results queue in a small FIFO and drain into idle write slots.
- A starvation counter requests a pipeline bubble so the queue always drains.
- Stale LLU results (WAW against a newer pipeline write) are killed, never written.

Parameters:
- DEPTH, 2, LLU result FIFO entries (power of two, >=2).
- STARVE_MAX, 4, consecutive cycles a live FIFO head may wait before o_pipe_stall is raised (>=1).

Ports:
- clk  in  1  clock, rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- i_wb_en  in  1  pipeline write request (WB stage o_dest_en).
- i_wb_reg  in  `REG_IDX_W  pipeline destination register.
- i_wb_data  in  `WORD_W  pipeline write data.
- i_ll_valid  in  1  LLU result valid.
- o_ll_ready  out  1  FIFO can accept an LLU result.
- i_ll_reg  in  `REG_IDX_W  LLU destination register.
- i_ll_data  in  `WORD_W  LLU result.
- o_rf_we  out  1  register-file write enable.
- o_rf_reg  out  `REG_IDX_W  register-file write index.
- o_rf_data  out  `WORD_W  register-file write data.
- o_pipe_stall  out  1  registered request for the pipeline to insert a WB bubble.
- o_ll_pending  out  1  FIFO non-empty (live or killed entries).

Behaviour:
- Reset (clr_n=0, asynchronous): FIFO empty, all kill bits 0, starvation counter 0, o_pipe_stall=0, o_ll_ready=1, o_ll_pending=0. o_rf_we is forced to 0 while clr_n=0. o_rf_reg and o_rf_data are 0.
- FIFO entry fields: {reg, data, kill}.
  - Push when i_ll_valid && o_ll_ready.
  - o_ll_ready = (count < DEPTH). It depends only on registered count; there is no same-cycle pop pass-through.
- Write-port grant (combinational, same cycle):
  - If i_wb_en && i_wb_reg != 0: grant pipeline; o_rf_we=1, o_rf_reg=i_wb_reg, o_rf_data=i_wb_data.
  - Else, if the FIFO head is live (not killed and reg != 0): grant head; o_rf_we=1 with head reg/data; pop.
  - Else: o_rf_we=0.
  - i_wb_en with reg 0 counts as an idle slot.
- Killed-head drain: a head with kill=1 or reg 0 pops every cycle regardless of the pipeline, without writing. This costs one cycle per killed entry.
- WAW kill: on a granted pipeline write to R, every FIFO entry with reg==R sets kill=1 at the clock edge. A same-cycle incoming push with i_ll_reg==R is stored with kill=1, because the pipeline write is newer.
- The pipeline never waits on this block. No pipeline write is ever dropped or delayed.
- Latency: an LLU result is written no earlier than the cycle after its push. Minimum push-to-write latency is 1 cycle.
- Starvation counter:
  - Increments each cycle the head is live and not granted.
  - Clears on a head grant, or when the head is killed or the FIFO is empty.
  - When the counter reaches STARVE_MAX, o_pipe_stall is set to 1 at the next edge.
  - o_pipe_stall clears at the edge after the head is granted.
  - While o_pipe_stall=1 the pipeline freezes its upper stages and presents i_wb_en=0 once its in-flight WB write retires.
  - The arbiter still grants any i_wb_en=1 while stalled.
- Simultaneous push and pop on a full FIFO: the pop happens; the push does not, because ready was 0. Count goes DEPTH -> DEPTH-1.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Reset mid-operation discards all queued results. Re-issue is the LLU's responsibility.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, i_ll_valid=1 and the pipeline slot is idle, the LLU result is written the same cycle (o_rf_* from i_ll_*) and not pushed. o_ll_ready then also equals 1 in that case. Minimum latency is 0.
- Undefined: all LLU results go through the FIFO; minimum latency is 1.

Decomposition:
- Shared macros in config.vh: `WORD_W, `REG_IDX_W, and new `WB_ARB_DEPTH / `WB_ARB_STARVE_MAX parameter defaults.
- One sub-module, wb_arb_fifo:
  - DEPTH-entry register FIFO with per-entry kill bits.
  - Inputs: a kill-match port (reg, enable).
  - Outputs: head and count.
- wb_arb holds the grant logic and the starvation counter.

Test Plan:
- Reset: clr_n=0 mid-stream with 2 entries queued -> o_ll_pending=0, o_rf_we=0, o_ll_ready=1 immediately, without waiting for a clock edge.
- Idle drain: push {r5, 0xDEAD}, i_wb_en=0 -> next cycle o_rf_we=1, o_rf_reg=5, o_rf_data=0xDEAD; FIFO empty after.
- Priority/full: push r3 and r4 while i_wb_en=1 (r7) each cycle -> o_ll_ready=0, a third push is held, and r7 writes are uninterrupted.
- WAW: queue {r9, 0x11}, then pipeline writes r9=0x22 -> when the slot frees, the r9 entry pops with o_rf_we=0, so r9 retains 0x22.
- Starvation: queue {r2, 0x5} with i_wb_en=1 continuously, STARVE_MAX=4 -> o_pipe_stall rises after 4 waiting cycles. Drive i_wb_en=0 -> r2 written, o_pipe_stall falls at the next edge.
- r0: pipeline write to r0 with a live head {r6, 0x7} -> head is granted that cycle; an LLU push to r0 pops without writing.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Types shared by the write-back arbiter and its LLU result FIFO.
`include "config.vh"
package wb_arb_pkg;
  localparam int unsigned WORD_W    = `WORD_W;
  localparam int unsigned REG_IDX_W = `REG_IDX_W;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [WORD_W-1:0]    data;
    logic                 kill;
  } ll_entry_t;
endpackage

// File: rtl/config.vh
// Shared datapath widths and wb_arb parameter defaults.
`ifndef CONFIG_VH
`define CONFIG_VH
`define WORD_W            32
`define REG_IDX_W         5
`define WB_ARB_DEPTH      2
`define WB_ARB_STARVE_MAX 4
`endif

// File: rtl/wb_arb_fifo.sv
// DEPTH-entry register FIFO of LLU results with per-entry WAW kill bits.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         push,
  input  ll_entry_t                    push_entry,
  input  logic                         pop,
  input  logic                         kill_en,
  input  logic [REG_IDX_W-1:0]         kill_reg,
  output ll_entry_t                    head,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ll_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  // Kill marking runs before the push write so a fresh entry keeps its own kill bit.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[i].rd == kill_reg) mem[i].kill <= 1'b1;
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: rtl/wb_arb.sv
// Register-file write-port arbiter: pipeline write-back first, queued LLU results in idle slots.
// Optional WB_ARB_BYPASS_EN lets an LLU result write straight through when the queue is empty.
`include "config.vh"
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = `WB_ARB_DEPTH,
  parameter int unsigned STARVE_MAX = `WB_ARB_STARVE_MAX
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 i_wb_en,
  input  logic [REG_IDX_W-1:0] i_wb_reg,
  input  logic [WORD_W-1:0]    i_wb_data,
  input  logic                 i_ll_valid,
  output logic                 o_ll_ready,
  input  logic [REG_IDX_W-1:0] i_ll_reg,
  input  logic [WORD_W-1:0]    i_ll_data,
  output logic                 o_rf_we,
  output logic [REG_IDX_W-1:0] o_rf_reg,
  output logic [WORD_W-1:0]    o_rf_data,
  output logic                 o_pipe_stall,
  output logic                 o_ll_pending
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  ll_entry_t        head;
  ll_entry_t        push_entry;
  logic [CNT_W-1:0] count;
  logic             wb_grant;
  logic             head_valid;
  logic             head_live;
  logic             ll_grant;
  logic             bypass;
  logic             pop;
  logic             push;
  logic [STV_W-1:0] starve_cnt;
  logic [STV_W-1:0] starve_nxt;
  logic             stall_nxt;

  // Grant, pop/push and write-port mux; dead heads drain even under a pipeline write.
  always_comb begin
    wb_grant   = i_wb_en && (i_wb_reg != '0);
    head_valid = (count != '0);
    head_live  = head_valid && !head.kill && (head.rd != '0);
    ll_grant   = !wb_grant && head_live;
    pop        = head_valid && (ll_grant || !head_live);
`ifdef WB_ARB_BYPASS_EN
    bypass     = !head_valid && i_ll_valid && !wb_grant;
`else
    bypass     = 1'b0;
`endif
    o_ll_ready = (count < CNT_W'(DEPTH)) || bypass;
    push       = i_ll_valid && o_ll_ready && !bypass;
    push_entry = '{rd: i_ll_reg, data: i_ll_data, kill: wb_grant && (i_ll_reg == i_wb_reg)};

    o_rf_we   = 1'b0;
    o_rf_reg  = '0;
    o_rf_data = '0;
    if (clr_n) begin
      if (wb_grant) begin
        o_rf_we   = 1'b1;
        o_rf_reg  = i_wb_reg;
        o_rf_data = i_wb_data;
      end else if (ll_grant) begin
        o_rf_we   = 1'b1;
        o_rf_reg  = head.rd;
        o_rf_data = head.data;
      end else if (bypass && (i_ll_reg != '0)) begin
        o_rf_we   = 1'b1;
        o_rf_reg  = i_ll_reg;
        o_rf_data = i_ll_data;
      end
    end
    o_ll_pending = head_valid;
  end

  // Starvation tracking: stall is requested once a live head has waited STARVE_MAX cycles.
  always_comb begin
    starve_nxt = '0;
    stall_nxt  = 1'b0;
    if (head_live && !ll_grant) begin
      starve_nxt = (starve_cnt >= STV_W'(STARVE_MAX)) ? starve_cnt : starve_cnt + STV_W'(1);
      stall_nxt  = o_pipe_stall || (starve_nxt >= STV_W'(STARVE_MAX));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      starve_cnt   <= '0;
      o_pipe_stall <= 1'b0;
    end else begin
      starve_cnt   <= starve_nxt;
      o_pipe_stall <= stall_nxt;
    end
  end

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .clr_n      (clr_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (wb_grant),
    .kill_reg   (i_wb_reg),
    .head       (head),
    .count      (count)
  );
endmodule

// File: tb/tb_wb_arb.sv
// Directed self-checking bench for wb_arb (default build, DEPTH=2, STARVE_MAX=4).
module tb_wb_arb;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          i_wb_en;
  logic [RW-1:0] i_wb_reg;
  logic [DW-1:0] i_wb_data;
  logic          i_ll_valid;
  logic          o_ll_ready;
  logic [RW-1:0] i_ll_reg;
  logic [DW-1:0] i_ll_data;
  logic          o_rf_we;
  logic [RW-1:0] o_rf_reg;
  logic [DW-1:0] o_rf_data;
  logic          o_pipe_stall;
  logic          o_ll_pending;

  int n_cmp = 0;
  int n_bad = 0;

  wb_arb dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .i_wb_en      (i_wb_en),
    .i_wb_reg     (i_wb_reg),
    .i_wb_data    (i_wb_data),
    .i_ll_valid   (i_ll_valid),
    .o_ll_ready   (o_ll_ready),
    .i_ll_reg     (i_ll_reg),
    .i_ll_data    (i_ll_data),
    .o_rf_we      (o_rf_we),
    .o_rf_reg     (o_rf_reg),
    .o_rf_data    (o_rf_data),
    .o_pipe_stall (o_pipe_stall),
    .o_ll_pending (o_ll_pending)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [RW-1:0] wr, input logic [DW-1:0] wd,
                       input logic lv, input logic [RW-1:0] lr, input logic [DW-1:0] ld);
    i_wb_en = we; i_wb_reg = wr; i_wb_data = wd;
    i_ll_valid = lv; i_ll_reg = lr; i_ll_data = ld;
  endtask

  // Inputs change just after the rising edge; checks happen at the falling edge.
  task automatic mid;
    @(negedge clk);
  endtask

  task automatic next_cyc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    drive(1'b1, 5'd7, 32'h1234, 1'b1, 5'd3, 32'h3);
    #2;
    n_cmp++; if (o_rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", o_rf_we); end
    n_cmp++; if (o_rf_reg !== 5'd0 || o_rf_data !== 32'd0) begin n_bad++; $display("FAIL reset_rf got=%0d/%h want=0/0", o_rf_reg, o_rf_data); end
    n_cmp++; if (o_ll_ready !== 1'b1 || o_ll_pending !== 1'b0 || o_pipe_stall !== 1'b0) begin n_bad++; $display("FAIL reset_flags got rdy=%b pend=%b stall=%b want 1/0/0", o_ll_ready, o_ll_pending, o_pipe_stall); end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    next_cyc;
    clr_n = 1'b1;
    next_cyc;
  endtask

  task automatic test_idle_drain;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD);
    mid;
    n_cmp++; if (o_rf_we !== 1'b0) begin n_bad++; $display("FAIL drain_no_bypass got=%b want=0", o_rf_we); end
    next_cyc;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_rf_we !== 1'b1 || o_rf_reg !== 5'd5 || o_rf_data !== 32'hDEAD) begin n_bad++; $display("FAIL drain_write got=%b/%0d/%h want=1/5/dead", o_rf_we, o_rf_reg, o_rf_data); end
    next_cyc;
    mid;
    n_cmp++; if (o_ll_pending !== 1'b0 || o_rf_we !== 1'b0) begin n_bad++; $display("FAIL drain_empty got pend=%b we=%b want 0/0", o_ll_pending, o_rf_we); end
    next_cyc;
  endtask

  task automatic test_priority_full;
    drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd3, 32'h3);
    mid;
    n_cmp++; if (o_rf_we !== 1'b1 || o_rf_reg !== 5'd7 || o_rf_data !== 32'h70) begin n_bad++; $display("FAIL prio_c1 got=%b/%0d/%h want=1/7/70", o_rf_we, o_rf_reg, o_rf_data); end
    next_cyc;
    drive(1'b1, 5'd7, 32'h71, 1'b1, 5'd4, 32'h4);
    mid;
    n_cmp++; if (o_rf_reg !== 5'd7 || o_rf_data !== 32'h71 || o_ll_ready !== 1'b1) begin n_bad++; $display("FAIL prio_c2 got=%0d/%h rdy=%b want=7/71 rdy=1", o_rf_reg, o_rf_data, o_ll_ready); end
    next_cyc;
    drive(1'b1, 5'd7, 32'h72, 1'b1, 5'd8, 32'h8);
    mid;
    n_cmp++; if (o_ll_ready !== 1'b0 || o_rf_reg !== 5'd7 || o_rf_data !== 32'h72) begin n_bad++; $display("FAIL prio_full got rdy=%b %0d/%h want rdy=0 7/72", o_ll_ready, o_rf_reg, o_rf_data); end
    next_cyc;
    drive(1'b1, 5'd7, 32'h73, 1'b1, 5'd8, 32'h8);
    mid;
    n_cmp++; if (o_ll_ready !== 1'b0 || o_rf_data !== 32'h73 || o_pipe_stall !== 1'b0) begin n_bad++; $display("FAIL prio_hold got rdy=%b data=%h stall=%b want 0/73/0", o_ll_ready, o_rf_data, o_pipe_stall); end
    next_cyc;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8);
    mid;
    n_cmp++; if (o_rf_we !== 1'b1 || o_rf_reg !== 5'd3 || o_rf_data !== 32'h3 || o_ll_ready !== 1'b0) begin n_bad++; $display("FAIL full_pop got=%b/%0d/%h rdy=%b want=1/3/3 rdy=0", o_rf_we, o_rf_reg, o_rf_data, o_ll_ready); end
    next_cyc;
    mid;
    n_cmp++; if (o_rf_reg !== 5'd4 || o_rf_data !== 32'h4 || o_ll_ready !== 1'b1) begin n_bad++; $display("FAIL pop_push got=%0d/%h rdy=%b want=4/4 rdy=1", o_rf_reg, o_rf_data, o_ll_ready); end
    next_cyc;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_rf_we !== 1'b1 || o_rf_reg !== 5'd8 || o_rf_data !== 32'h8) begin n_bad++; $display("FAIL third_push got=%b/%0d/%h want=1/8/8", o_rf_we, o_rf_reg, o_rf_data); end
    next_cyc;
    mid;
    n_cmp++; if (o_ll_pending !== 1'b0) begin n_bad++; $display("FAIL prio_empty got=%b want=0", o_ll_pending); end
    next_cyc;
  endtask

  task automatic test_waw;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h11);
    next_cyc;
    drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_rf_we !== 1'b1 || o_rf_reg !== 5'd9 || o_rf_data !== 32'h22) begin n_bad++; $display("FAIL waw_pipe got=%b/%0d/%h want=1/9/22", o_rf_we, o_rf_reg, o_rf_data); end
    next_cyc;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_rf_we !== 1'b0 || o_ll_pending !== 1'b1) begin n_bad++; $display("FAIL waw_killed got we=%b pend=%b want 0/1", o_rf_we, o_ll_pending); end
    next_cyc;
    mid;
    n_cmp++; if (o_ll_pending !== 1'b0) begin n_bad++; $display("FAIL waw_popped got=%b want=0", o_ll_pending); end
    next_cyc;
    drive(1'b1, 5'd10, 32'hAA, 1'b1, 5'd10, 32'hBB);
    mid;
    n_cmp++; if (o_rf_reg !== 5'd10 || o_rf_data !== 32'hAA) begin n_bad++; $display("FAIL waw_same got=%0d/%h want=10/aa", o_rf_reg, o_rf_data); end
    next_cyc;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_rf_we !== 1'b0 || o_ll_pending !== 1'b1) begin n_bad++; $display("FAIL waw_same_kill got we=%b pend=%b want 0/1", o_rf_we, o_ll_pending); end
    next_cyc;
  endtask

  task automatic test_starvation;
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd2, 32'h5);
    next_cyc;
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      mid;
      n_cmp++; if (o_pipe_stall !== 1'b0 || o_rf_reg !== 5'd7) begin n_bad++; $display("FAIL starve_wait%0d got stall=%b reg=%0d want 0/7", c, o_pipe_stall, o_rf_reg); end
      next_cyc;
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_pipe_stall !== 1'b1) begin n_bad++; $display("FAIL starve_raise got=%b want=1", o_pipe_stall); end
    n_cmp++; if (o_rf_we !== 1'b1 || o_rf_reg !== 5'd2 || o_rf_data !== 32'h5) begin n_bad++; $display("FAIL starve_grant got=%b/%0d/%h want=1/2/5", o_rf_we, o_rf_reg, o_rf_data); end
    next_cyc;
    mid;
    n_cmp++; if (o_pipe_stall !== 1'b0 || o_ll_pending !== 1'b0) begin n_bad++; $display("FAIL starve_clear got stall=%b pend=%b want 0/0", o_pipe_stall, o_ll_pending); end
    next_cyc;
  endtask

  task automatic test_r0;
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd6, 32'h7);
    next_cyc;
    drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_rf_we !== 1'b1 || o_rf_reg !== 5'd6 || o_rf_data !== 32'h7) begin n_bad++; $display("FAIL r0_pipe_idle got=%b/%0d/%h want=1/6/7", o_rf_we, o_rf_reg, o_rf_data); end
    next_cyc;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
    next_cyc;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_rf_we !== 1'b0 || o_ll_pending !== 1'b1) begin n_bad++; $display("FAIL r0_ll_dead got we=%b pend=%b want 0/1", o_rf_we, o_ll_pending); end
    next_cyc;
    mid;
    n_cmp++; if (o_ll_pending !== 1'b0) begin n_bad++; $display("FAIL r0_ll_popped got=%b want=0", o_ll_pending); end
    next_cyc;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd1, 32'h10);
    next_cyc;
    drive(1'b1, 5'd7, 32'h2, 1'b1, 5'd2, 32'h20);
    next_cyc;
    drive(1'b1, 5'd7, 32'h3, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_ll_pending !== 1'b1 || o_ll_ready !== 1'b0) begin n_bad++; $display("FAIL pre_reset got pend=%b rdy=%b want 1/0", o_ll_pending, o_ll_ready); end
    #1 clr_n = 1'b0;
    #1;
    n_cmp++; if (o_ll_pending !== 1'b0 || o_ll_ready !== 1'b1 || o_rf_we !== 1'b0) begin n_bad++; $display("FAIL async_reset got pend=%b rdy=%b we=%b want 0/1/0", o_ll_pending, o_ll_ready, o_rf_we); end
    next_cyc;
    clr_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    mid;
    n_cmp++; if (o_rf_we !== 1'b0 || o_ll_pending !== 1'b0) begin n_bad++; $display("FAIL post_reset got we=%b pend=%b want 0/0", o_rf_we, o_ll_pending); end
    next_cyc;
  endtask

  initial begin
    test_reset;
    test_idle_drain;
    test_priority_full;
    test_waw;
    test_starvation;
    test_r0;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
